// File: rtl/cnn_relu_pool_pkg.sv
// rtl/cnn_relu_pool_pkg.sv - shared constants and types for the ReLU/pool stage
//
// Purpose: defaults for the stage that follows the 1-D systolic convolution
// block, plus the pooling-mode encoding used by the top.
//   WEIGHT_SIZE     : convolution output lane count (default LANES)
//   POOL_FIFO_DEPTH : entries per lane output FIFO
//   POOL_SHIFT_W    : width of the requantise shift amount
package cnn_relu_pool_pkg;

  localparam int WEIGHT_SIZE     = 3;
  localparam int POOL_FIFO_DEPTH = 4;
  localparam int POOL_SHIFT_W    = 5;

  typedef enum logic {
    POOL_BYPASS = 1'b0,
    POOL_MAX2   = 1'b1
  } pool_mode_e;

endpackage

// File: rtl/cnn_lane_fifo.sv
// rtl/cnn_lane_fifo.sv - per-lane circular output FIFO with occupancy count
//
// Purpose: buffers one lane's pooled samples until the consumer pops them.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   push, push_data : write request and data (ignored when full)
//   pop             : read request (ignored when empty)
//   head            : oldest entry, valid while empty=0
//   empty, full     : derived from the registered count
module cnn_lane_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cnn_relu_pool.sv
// rtl/cnn_relu_pool.sv - per-lane requantise, ReLU, 2:1 max-pool and output FIFO
//
// Purpose: post-processes the convolution block's per-lane partial results.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   conv_data   : lane i at [i*DATA_W +: DATA_W], signed
//   conv_valid  : per-lane sample valid
//   conv_stall  : back to the convolution block, high while any FIFO is full
//   cfg_shift   : arithmetic right-shift applied before ReLU
//   cfg_pool_en : 1 = max of consecutive pairs, 0 = every sample forwarded
//   pool_clear  : drops every lane's pending half-pair
//   out_data    : per-lane FIFO head
//   out_valid   : per-lane FIFO non-empty
//   out_ready   : per-lane pop
module cnn_relu_pool
  import cnn_relu_pool_pkg::*;
#(
  parameter int LANES      = WEIGHT_SIZE,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = POOL_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATA_W-1:0] conv_data,
  input  logic [LANES-1:0]        conv_valid,
  output logic                    conv_stall,
  input  logic [POOL_SHIFT_W-1:0] cfg_shift,
  input  logic                    cfg_pool_en,
  input  logic                    pool_clear,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_valid,
  input  logic [LANES-1:0]        out_ready
);

  logic [LANES-1:0] lane_full;
  logic [LANES-1:0] lane_empty;
  pool_mode_e       mode;

  assign mode       = pool_mode_e'(cfg_pool_en);
  // Global stall from registered counts only, so it never loops through out_ready.
  assign conv_stall = |lane_full;
  assign out_valid  = ~lane_empty;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DATA_W-1:0] q;
    logic        [DATA_W-1:0] r;
    logic        [DATA_W-1:0] pend_val;
    logic        [DATA_W-1:0] push_data;
    logic                     pend;
    logic                     accept;
    logic                     push;

    assign accept = conv_valid[g] & ~conv_stall;
    assign q      = $signed(conv_data[g*DATA_W +: DATA_W]) >>> cfg_shift;
    assign r      = q[DATA_W-1] ? '0 : q;

    // Both pool operands are already clipped to >= 0, so unsigned max is exact.
    always_comb begin
      push      = accept;
      push_data = r;
      if (mode == POOL_MAX2) begin
        push      = accept & pend;
        push_data = (pend_val > r) ? pend_val : r;
      end
    end

    // pool_clear overrides the toggle, so a first-half accept in a clear
    // cycle is dropped while a second-half accept still completes its push.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pend     <= 1'b0;
        pend_val <= '0;
      end else begin
        if (accept && !pend) pend_val <= r;
        if (pool_clear || mode == POOL_BYPASS) pend <= 1'b0;
        else if (accept)                       pend <= ~pend;
      end
    end

    cnn_lane_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (out_ready[g]),
      .head      (out_data[g*DATA_W +: DATA_W]),
      .empty     (lane_empty[g]),
      .full      (lane_full[g])
    );
  end

endmodule

// File: tb/tb_cnn_relu_pool.sv
// tb/tb_cnn_relu_pool.sv - scoreboard bench for cnn_relu_pool
module tb_cnn_relu_pool;

  localparam int L = 3;
  localparam int W = 32;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [L*W-1:0] conv_data;
  logic [L-1:0]   conv_valid;
  logic           conv_stall;
  logic [4:0]     cfg_shift;
  logic           cfg_pool_en;
  logic           pool_clear;
  logic [L*W-1:0] out_data;
  logic [L-1:0]   out_valid;
  logic [L-1:0]   out_ready;

  cnn_relu_pool #(.LANES(L), .DATA_W(W), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .conv_data   (conv_data),
    .conv_valid  (conv_valid),
    .conv_stall  (conv_stall),
    .cfg_shift   (cfg_shift),
    .cfg_pool_en (cfg_pool_en),
    .pool_clear  (pool_clear),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q [L][$];
  int          pushed_now [L];
  bit          pend_m [L];
  logic [31:0] pend_v [L];
  bit          hold [L];
  logic [31:0] hold_d [L];
  bit          pool_m = 1'b0;
  int          shift_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Floor of x / 2^sh, then clipped at zero.
  function automatic logic [31:0] model_r(input logic [31:0] x, input int sh);
    longint v;
    v = longint'($signed(x));
    while (sh > 0) begin
      v = (v < 0) ? -((-v + 1) / 2) : v / 2;
      sh--;
    end
    return (v < 0) ? 32'd0 : 32'(v);
  endfunction

  function automatic logic [31:0] rand_sample();
    case ($urandom_range(2))
      0:       return 32'($signed($urandom_range(200)) - 100);
      1:       return $urandom & 32'h0000_ffff;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [L*W-1:0] one(input int lane, input logic [31:0] v);
    logic [L*W-1:0] d;
    d = '0;
    d[lane*W +: W] = v;
    return d;
  endfunction

  // Drives one cycle's inputs and predicts what the stage must accept/push.
  task automatic cycle(input logic [L-1:0] want, input logic [L*W-1:0] dat,
                       input bit rnd, input logic [L-1:0] rdy, input bit clr);
    logic [L-1:0]   v;
    logic [L*W-1:0] d;
    bit             stall_m;
    logic [31:0]    r;
    @(posedge clk);
    #1;
    stall_m = 1'b0;
    for (int i = 0; i < L; i++) begin
      pushed_now[i] = 0;
      if (exp_q[i].size() >= D) stall_m = 1'b1;
    end
    v = '0;
    d = '0;
    for (int i = 0; i < L; i++) begin
      if (hold[i]) begin
        v[i] = 1'b1;
      end else if (want[i]) begin
        v[i] = 1'b1;
        hold_d[i] = rnd ? rand_sample() : dat[i*W +: W];
      end
      if (v[i]) begin
        d[i*W +: W] = hold_d[i];
        if (stall_m) begin
          hold[i] = 1'b1;
        end else begin
          hold[i] = 1'b0;
          r = model_r(hold_d[i], shift_m);
          if (!pool_m) begin
            exp_q[i].push_back(r);
            pushed_now[i]++;
          end else if (pend_m[i]) begin
            exp_q[i].push_back((pend_v[i] > r) ? pend_v[i] : r);
            pushed_now[i]++;
            pend_m[i] = 1'b0;
          end else begin
            pend_v[i] = r;
            pend_m[i] = 1'b1;
          end
        end
      end
      if (clr || !pool_m) pend_m[i] = 1'b0;
    end
    conv_valid  = v;
    conv_data   = d;
    out_ready   = rdy;
    pool_clear  = clr;
    cfg_shift   = 5'(shift_m);
    cfg_pool_en = pool_m;
  endtask

  task automatic idle(input int n, input logic [L-1:0] rdy);
    for (int k = 0; k < n; k++) cycle('0, '0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    conv_valid = '0;
    pool_clear = 1'b0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < L; i++) begin
      exp_q[i].delete();
      pushed_now[i] = 0;
      pend_m[i] = 1'b0;
      hold[i] = 1'b0;
    end
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset conv_stall", 32'(conv_stall), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: checks visibility, stall and popped data against the scoreboard.
  always @(negedge clk) begin
    bit st;
    int c;
    if (rst) begin
      st = 1'b0;
      for (int i = 0; i < L; i++) begin
        c = exp_q[i].size() - pushed_now[i];
        if (c >= D) st = 1'b1;
        check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(c > 0));
      end
      check("conv_stall", 32'(conv_stall), 32'(st));
      for (int i = 0; i < L; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() > 0) begin
            check($sformatf("out_data[%0d]", i), out_data[i*W +: W], exp_q[i][0]);
            void'(exp_q[i].pop_front());
          end else begin
            check($sformatf("spurious pop[%0d]", i), 32'(out_valid[i]), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    conv_data = '0;
    conv_valid = '0;
    cfg_shift = '0;
    cfg_pool_en = 1'b0;
    pool_clear = 1'b0;
    out_ready = '0;
    for (int i = 0; i < L; i++) begin
      pushed_now[i] = 0;
      pend_m[i] = 1'b0;
      hold[i] = 1'b0;
    end
    #2;
    rst = 1'b0;
    #1;
    check("init out_valid", 32'(out_valid), 32'd0);
    check("init conv_stall", 32'(conv_stall), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Bypass, shift 2: -20, 13, 8 -> 0, 3, 2.
    shift_m = 2; pool_m = 1'b0;
    cycle(3'b001, one(0, -32'sd20), 1'b0, '1, 1'b0);
    cycle(3'b001, one(0, 32'd13),   1'b0, '1, 1'b0);
    cycle(3'b001, one(0, 32'd8),    1'b0, '1, 1'b0);
    idle(3, '1);

    // Pool, shift 0, lane1: 5, 9, 7, -4 -> 9, 7.
    shift_m = 0; pool_m = 1'b1;
    cycle('0, '0, 1'b0, '1, 1'b1);
    cycle(3'b010, one(1, 32'd5),    1'b0, '1, 1'b0);
    cycle(3'b010, one(1, 32'd9),    1'b0, '1, 1'b0);
    cycle(3'b010, one(1, 32'd7),    1'b0, '1, 1'b0);
    cycle(3'b010, one(1, -32'sd4),  1'b0, '1, 1'b0);
    idle(3, '1);

    // Staggered lanes with pooling.
    for (int k = 0; k < 18; k++) cycle(3'(1 << (k % 3)), '0, 1'b1, '1, 1'b0);
    idle(3, '1);

    // Backpressure in bypass: fill lane0, then release one pop.
    pool_m = 1'b0;
    for (int k = 0; k < 7; k++) cycle(3'b001, '0, 1'b1, '0, 1'b0);
    cycle(3'b001, '0, 1'b1, 3'b001, 1'b0);
    cycle(3'b000, '0, 1'b1, '0, 1'b0);
    cycle(3'b000, '0, 1'b1, '0, 1'b0);
    idle(8, '1);

    // pool_clear: 10, clear, 3, 6 -> single 6.
    pool_m = 1'b1;
    cycle('0, '0, 1'b0, '1, 1'b1);
    cycle(3'b001, one(0, 32'd10), 1'b0, '1, 1'b0);
    cycle('0, '0, 1'b0, '1, 1'b1);
    cycle(3'b001, one(0, 32'd3),  1'b0, '1, 1'b0);
    cycle(3'b001, one(0, 32'd6),  1'b0, '1, 1'b0);
    idle(3, '1);

    // Clear in the same cycle as accepts on both halves of a pair.
    cycle(3'b011, '0, 1'b1, '1, 1'b0);
    cycle(3'b011, '0, 1'b1, '1, 1'b1);
    cycle(3'b011, '0, 1'b1, '1, 1'b1);
    idle(3, '1);

    // Async reset with 3 entries queued and a pending half.
    for (int k = 0; k < 7; k++) cycle(3'b001, '0, 1'b1, '0, 1'b0);
    check("queued before reset", 32'(exp_q[0].size()), 32'd3);
    do_reset();
    pool_m = 1'b1; shift_m = 0;
    cycle(3'b001, one(0, 32'd1), 1'b0, '1, 1'b0);
    cycle(3'b001, one(0, 32'd2), 1'b0, '1, 1'b0);
    idle(3, '1);

    // Randomized phases.
    for (int p = 0; p < 4; p++) begin
      shift_m = int'($urandom_range(31));
      pool_m  = bit'(p % 2);
      cycle('0, '0, 1'b0, '1, 1'b1);
      for (int k = 0; k < 300; k++)
        cycle(3'($urandom), '0, 1'b1, 3'($urandom), ($urandom_range(15) == 0));
      if (p == 1) do_reset();
    end
    idle(25, '1);
    for (int i = 0; i < L; i++)
      check($sformatf("drained[%0d]", i), 32'(exp_q[i].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnn_relu_pool.md
Name: cnn_relu_pool

Overview:
- Stage directly downstream of the 1-D systolic convolution block.
- Consumes the WEIGHT_SIZE per-lane 32-bit partial results and their per-lane valids.
- Per lane: arithmetic right-shift requantise, ReLU, optional 2:1 max-pool over consecutive accepted samples, then buffering in a per-lane FIFO.
- Drives the convolution block's stall input when any lane FIFO is full.

Parameters:
- LANES, `WEIGHT_SIZE, number of convolution output lanes.
- DATA_W, 32, sample width in bits (signed two's complement).
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, ≥2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset: assertion (rst=0) clears all state immediately; release is synchronous to clk.
- conv_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- conv_valid  in  LANES  per-lane valid; lanes may be valid in different cycles.
- conv_stall  out  LANES? no: 1  stall to the convolution block.
- cfg_shift  in  5  arithmetic right-shift amount; held static while data flows.
- cfg_pool_en  in  1  1 = 2:1 max-pool, 0 = bypass (every sample pushed); held static while data flows.
- pool_clear  in  1  discards every lane's pending half-pair this cycle.
- out_data  out  LANES*DATA_W  FIFO head per lane.
- out_valid  out  LANES  lane FIFO non-empty.
- out_ready  in  LANES  per-lane pop.

Behaviour:
- Reset values: out_valid=0, conv_stall=0, FIFO pointers and counts=0, pending flags=0. out_data is don't-care while out_valid=0.
- conv_stall = OR over lanes of (count==FIFO_DEPTH).
  - Combinational from registered counts only; it must not depend on out_ready.
- Accept rule: lane i accepts in a cycle iff conv_valid[i] & ~conv_stall.
  - When stall and valid are both high, the convolution block holds its outputs. The sample is therefore not consumed, and it is re-presented later.
- Requantise: q = $signed(x) >>> cfg_shift.
- ReLU: r = (q<0) ? 0 : q. Result width DATA_W.
- Pool path, per lane, cfg_pool_en=1. Keeps a pend_val register and a pend flag.
  - accept with pend=0: pend_val<=r, pend<=1, no push.
  - accept with pend=1: push max(pend_val,r) (unsigned compare is sufficient, both ≥0); pend<=0.
  - Push happens in the same cycle as the accept: FIFO write, visible on out_valid next cycle.
- Bypass, cfg_pool_en=0: every accept pushes r. pend is forced to 0.
- Latency: push to out_valid is 1 cycle. A sample accepted at cycle t appears at the FIFO head at t+1 if the FIFO was empty.
- FIFO: circular, with a count register.
  - Pop when out_valid[i] & out_ready[i].
  - Simultaneous push and pop on a full FIFO cannot occur, because stall blocks the push.
  - Simultaneous push and pop at any other count leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop on an empty FIFO is ignored.
- pool_clear:
  - Clears pend on all lanes.
  - If asserted in the same cycle as an accept, the clear wins for the pending state: a pend=1 accept still pushes the completed pair, and a pend=0 accept is dropped.
  - FIFO contents are not affected.
- Stall interaction: a lane with a non-full FIFO is still blocked when another lane is full, because stall is global. Its valid sample is held by the convolution block, so no data is lost.
- Reset mid-operation: all FIFO contents and pending halves are discarded immediately; conv_stall drops to 0 asynchronously.
- Arithmetic: no overflow is possible; the shift only reduces magnitude and ReLU clips the sign.

Decomposition:
- CNNConfig.vh gains `POOL_FIFO_DEPTH (default 4) and `POOL_SHIFT_W (5). LANES defaults from `WEIGHT_SIZE.
- One sub-module: cnn_lane_fifo.
  - Parameterised DATA_W/FIFO_DEPTH.
  - Ports: push, push_data, pop, head, empty, full.
  - Instantiated LANES times in a generate loop.
- Requantise/ReLU/pool logic stays in the top, per lane.

Test Plan:
- Bypass, cfg_shift=2, lane0 accepts -20, 13, 8 on consecutive cycles, out_ready=1 → out_data lane0 = 0, 3, 2 on cycles t+1..t+3.
- Pool, cfg_shift=0, lane1 accepts 5, 9, 7, -4 → pushes 9 then 7, each one cycle after the second sample of its pair.
- Staggered lanes (LANES=3, valid lane0 at t, lane1 at t+1, lane2 at t+2, repeated), pool on → each lane independently emits max of its own pairs; no cross-lane mixing.
- Backpressure: out_ready=0, bypass, FIFO_DEPTH=4, lane0 fed continuously.
  - After 4 accepts, conv_stall=1 and the held sample is not consumed.
  - Raise out_ready for 1 cycle → conv_stall=0 next cycle and the held sample is pushed exactly once.
- pool_clear, pool on: accept 10, assert pool_clear, accept 3, 6 → single push of 6; 10 is never emitted.
- Async reset: assert rst=0 mid-stream with 3 entries queued and pend=1 → out_valid=0 and conv_stall=0 immediately; after release, the first two accepts 1, 2 yield a push of 2.
